stmm_writeback: RTL and testbench

- Write-direction counterpart of the StMM parameter/weight fetch path.
- Captures one StMM sub-unit's output vector (N x 8-bit) when the controller issues a store.
- Streams the vector to SDRAM as SDRAM_W-bit beats over a valid/ready write port, then pulses done.
- Sits beside the StMM wrapper, between the sub-unit Y outputs and the SDRAM write arbiter.

---
 rtl/stmm_writeback_if.sv | 35 +++
 rtl/stmm_writeback.sv | 126 ++++++++++++
 tb/tb_stmm_writeback.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/stmm_writeback_if.sv
// -----------------------------------------------------------------------------
// stmm_writeback_if
// SDRAM write-port bundle used by the StMM write-back engine.
//   wr_valid : beat valid                 (master -> slave)
//   wr_ready : slave accepts the beat     (slave  -> master)
//   wr_addr  : word address of the beat   (master -> slave)
//   wr_data  : beat data                  (master -> slave)
//   wr_last  : final beat of the vector   (master -> slave)
// -----------------------------------------------------------------------------
interface stmm_writeback_if #(
    parameter int ADDR_W  = 24,
    parameter int SDRAM_W = 128
);
    logic               wr_valid;
    logic               wr_ready;
    logic [ADDR_W-1:0]  wr_addr;
    logic [SDRAM_W-1:0] wr_data;
    logic               wr_last;

    modport master (
        output wr_valid,
        input  wr_ready,
        output wr_addr,
        output wr_data,
        output wr_last
    );

    modport slave (
        input  wr_valid,
        output wr_ready,
        input  wr_addr,
        input  wr_data,
        input  wr_last
    );
endinterface

// File: rtl/stmm_writeback.sv
// -----------------------------------------------------------------------------
// stmm_writeback
// Captures one StMM sub-unit output vector (N x 8 bit) on a store request and
// streams it to SDRAM as SDRAM_W-bit beats over a valid/ready write port,
// then pulses done for one cycle.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   y_data     : concatenated sub-unit outputs, sub k at [k*N*8 +: N*8]
//   start      : store request, sampled only while idle
//   sub_idx    : sub-unit to store, sampled with start
//   store_addr : word address of the first beat, sampled with start
//   wr         : SDRAM write port (master side)
//   busy       : transfer in progress
//   done       : one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module stmm_writeback #(
    parameter int SUB_NUM = 4,
    parameter int N       = 176,
    parameter int SDRAM_W = 128,
    parameter int ADDR_W  = 24,
    localparam int SEL_W  = (SUB_NUM > 1) ? $clog2(SUB_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SUB_NUM*N*8-1:0]   y_data,
    input  logic                     start,
    input  logic [SEL_W-1:0]         sub_idx,
    input  logic [ADDR_W-1:0]        store_addr,
    stmm_writeback_if.master         wr,
    output logic                     busy,
    output logic                     done
);
    localparam int VEC_W = N * 8;
    localparam int BEATS = (VEC_W + SDRAM_W - 1) / SDRAM_W;
    // Buffer is rounded up to whole beats so the last beat is zero-padded.
    localparam int BUF_W = BEATS * SDRAM_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t             r_state_reg, w_state_next;
    logic [BUF_W-1:0]   r_buf_reg,   w_buf_next;
    logic [ADDR_W-1:0]  r_addr_reg,  w_addr_next;
    logic [CNT_W-1:0]   r_cnt_reg,   w_cnt_next;
    logic               r_done_reg,  w_done_next;

    logic [VEC_W-1:0]   w_slice [SUB_NUM];
    logic [VEC_W-1:0]   w_sel_vec;
    logic               w_fire;
    logic               w_is_last;

    genvar gi;
    generate
        for (gi = 0; gi < SUB_NUM; gi++) begin : g_slice
            assign w_slice[gi] = y_data[gi*VEC_W +: VEC_W];
        end
    endgenerate

    // Out-of-range indices fall through to all-zero data.
    always_comb begin
        w_sel_vec = '0;
        for (int k = 0; k < SUB_NUM; k++) begin
            if (sub_idx == SEL_W'(k)) begin
                w_sel_vec = w_slice[k];
            end
        end
    end

    assign w_fire    = (r_state_reg == S_SEND) && wr.wr_ready;
    assign w_is_last = (r_cnt_reg == LAST_BEAT);

    always_comb begin
        w_state_next = r_state_reg;
        w_buf_next   = r_buf_reg;
        w_addr_next  = r_addr_reg;
        w_cnt_next   = r_cnt_reg;
        w_done_next  = 1'b0;
        case (r_state_reg)
            S_IDLE: begin
                if (start) begin
                    w_buf_next   = BUF_W'(w_sel_vec);
                    w_addr_next  = store_addr;
                    w_cnt_next   = '0;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_fire) begin
                    w_buf_next  = r_buf_reg >> SDRAM_W;
                    w_addr_next = r_addr_reg + ADDR_W'(1);
                    w_cnt_next  = r_cnt_reg + CNT_W'(1);
                    if (w_is_last) begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg <= S_IDLE;
            r_buf_reg   <= '0;
            r_addr_reg  <= '0;
            r_cnt_reg   <= '0;
            r_done_reg  <= 1'b0;
        end else begin
            r_state_reg <= w_state_next;
            r_buf_reg   <= w_buf_next;
            r_addr_reg  <= w_addr_next;
            r_cnt_reg   <= w_cnt_next;
            r_done_reg  <= w_done_next;
        end
    end

    // Outputs come straight from registers, so they hold while stalled.
    assign wr.wr_valid = (r_state_reg == S_SEND);
    assign wr.wr_data  = r_buf_reg[SDRAM_W-1:0];
    assign wr.wr_addr  = r_addr_reg;
    assign wr.wr_last  = (r_state_reg == S_SEND) && w_is_last;
    assign busy        = (r_state_reg == S_SEND);
    assign done        = r_done_reg;
endmodule

// File: tb/tb_stmm_writeback.sv
module tb_stmm_writeback;
    localparam int SUB_NUM = 4;
    localparam int N       = 176;
    localparam int SDRAM_W = 128;
    localparam int ADDR_W  = 24;
    localparam int BEATS   = 11;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [SUB_NUM*N*8-1:0] y_data;
    logic                   start;
    logic [1:0]             sub_idx;
    logic [ADDR_W-1:0]      store_addr;
    logic                   busy;
    logic                   done;

    int n_checks = 0;
    int n_err    = 0;

    stmm_writeback_if #(.ADDR_W(ADDR_W), .SDRAM_W(SDRAM_W)) wr_if ();

    stmm_writeback #(
        .SUB_NUM(SUB_NUM), .N(N), .SDRAM_W(SDRAM_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .y_data     (y_data),
        .start      (start),
        .sub_idx    (sub_idx),
        .store_addr (store_addr),
        .wr         (wr_if),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] elem(input int k, input int j);
        logic [7:0] jb;
        jb = 8'(j);
        case (k)
            0:       elem = 8'h55 ^ jb;
            1:       elem = ~jb;
            2:       elem = jb;
            default: elem = jb + 8'd3;
        endcase
    endfunction

    function automatic logic [127:0] exp_beat(input int k, input int b);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            if (16*b + i < N) v[8*i +: 8] = elem(k, 16*b + i);
        end
        return v;
    endfunction

    task automatic fill_y();
        for (int k = 0; k < SUB_NUM; k++)
            for (int j = 0; j < N; j++)
                y_data[(k*N + j)*8 +: 8] = elem(k, j);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int k, input logic [23:0] a, input int b);
        chk({tag, " valid"}, 128'(wr_if.wr_valid), 128'(1));
        chk({tag, " busy"},  128'(busy),           128'(1));
        chk({tag, " done"},  128'(done),           128'(0));
        chk({tag, " addr"},  128'(wr_if.wr_addr),  128'(24'(a + 24'(b))));
        chk({tag, " data"},  wr_if.wr_data,        exp_beat(k, b));
        chk({tag, " last"},  128'(wr_if.wr_last),  128'(b == BEATS-1));
        $display("%s beat %0d addr=%06h data=%032h last=%0b", tag, b, wr_if.wr_addr, wr_if.wr_data, wr_if.wr_last);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, " done"},  128'(done),           128'(1));
        chk({tag, " valid"}, 128'(wr_if.wr_valid), 128'(0));
        chk({tag, " busy"},  128'(busy),           128'(0));
        $display("%s done pulse", tag);
    endtask

    // Issues a store with ready tied high; returns at the done cycle.
    task automatic do_store(input string tag, input int k, input logic [23:0] a);
        start = 1'b1; sub_idx = 2'(k); store_addr = a;
        tick();
        start = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            chk_beat(tag, k, a, b);
            tick();
        end
        chk_done(tag);
    endtask

    initial begin
        logic [127:0] beat0_hand;
        logic [127:0] beat10_hand;
        int beat;
        int cyc;
        logic [3:0] rdy_pat;

        beat0_hand  = 128'h0F0E0D0C0B0A09080706050403020100;
        beat10_hand = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
        rdy_pat     = 4'b1001; // bit c%4 = ready in cycle c: 1,0,0,1

        rst = 1'b1; start = 1'b0; sub_idx = '0; store_addr = '0;
        wr_if.wr_ready = 1'b1;
        fill_y();
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst valid", 128'(wr_if.wr_valid), 128'(0));
        chk("rst last",  128'(wr_if.wr_last),  128'(0));
        chk("rst busy",  128'(busy),           128'(0));
        chk("rst done",  128'(done),           128'(0));
        chk("rst addr",  128'(wr_if.wr_addr),  128'(0));
        chk("rst data",  wr_if.wr_data,        128'(0));

        // Store sub 2 at 0x100, ready=1, with hand-computed beat 0 / beat 10
        start = 1'b1; sub_idx = 2'd2; store_addr = 24'h000100;
        tick();
        start = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            chk_beat("t1", 2, 24'h000100, b);
            if (b == 0)  chk("t1 beat0 hand",  wr_if.wr_data, beat0_hand);
            if (b == 10) chk("t1 beat10 hand", wr_if.wr_data, beat10_hand);
            tick();
        end
        chk_done("t1");
        tick();
        chk("t1 done one cycle", 128'(done), 128'(0));

        // Same store with ready 1,0,0,1 repeating; y_data clobbered after start
        start = 1'b1; sub_idx = 2'd2; store_addr = 24'h000100;
        tick();
        start = 1'b0;
        y_data = '1;
        beat = 0;
        cyc  = 0;
        while (beat < BEATS && cyc < 200) begin
            wr_if.wr_ready = rdy_pat[cyc % 4];
            chk_beat("t2", 2, 24'h000100, beat);
            if (wr_if.wr_ready) beat++;
            cyc++;
            tick();
        end
        chk("t2 accepted beats", 128'(beat), 128'(BEATS));
        chk_done("t2");
        wr_if.wr_ready = 1'b1;
        fill_y();
        tick();
        chk("t2 done one cycle", 128'(done), 128'(0));

        // start during SEND is ignored
        start = 1'b1; sub_idx = 2'd0; store_addr = 24'h000300;
        tick();
        start = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            chk_beat("t3", 0, 24'h000300, b);
            if (b == 2) begin
                start = 1'b1; sub_idx = 2'd1; store_addr = 24'h000999;
            end
            tick();
            start = 1'b0;
        end
        chk_done("t3");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t3 no second done", 128'(done), 128'(0));
            chk("t3 no requeue", 128'(wr_if.wr_valid), 128'(0));
        end

        // Reset after the 5th accepted beat
        start = 1'b1; sub_idx = 2'd3; store_addr = 24'h000400;
        tick();
        start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            chk_beat("t4", 3, 24'h000400, b);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4 valid", 128'(wr_if.wr_valid), 128'(0));
        chk("t4 busy",  128'(busy),           128'(0));
        chk("t4 last",  128'(wr_if.wr_last),  128'(0));
        chk("t4 addr",  128'(wr_if.wr_addr),  128'(0));
        chk("t4 data",  wr_if.wr_data,        128'(0));
        for (int c = 0; c < 12; c++) begin
            chk("t4 no done", 128'(done), 128'(0));
            tick();
        end
        do_store("t4b", 1, 24'h000500);
        tick();

        // Address wrap
        do_store("t5", 2, 24'hFFFFFA);
        tick();

        // start in the done cycle is accepted
        do_store("t6a", 0, 24'h000600);
        start = 1'b1; sub_idx = 2'd3; store_addr = 24'h000200;
        tick();
        start = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            chk_beat("t6b", 3, 24'h000200, b);
            tick();
        end
        chk_done("t6b");
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
